// File: rtl/sap_ctrl_pkg.sv
// Shared types for the SAP control sequencer: opcodes, FSM states, control word.
// Pure declarations; no timing of its own.
package sap_ctrl_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_LDB = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_OUT = 4'h5;
  localparam logic [3:0] OP_CMP = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_T1   = 2'd1,
    ST_T2   = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  typedef struct packed {
    logic       la_n;
    logic       lb_n;
    logic       ea;
    logic       eu;
    logic       sub;
    logic       out_sel;
    logic       out_strobe;
    logic [7:0] data_out;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_DEFAULT = '{
    la_n:       1'b1,
    lb_n:       1'b1,
    ea:         1'b0,
    eu:         1'b0,
    sub:        1'b0,
    out_sel:    1'b0,
    out_strobe: 1'b0,
    data_out:   8'h00
  };

  // Opcodes that need a T2 slot: loads (bus transfer) and ALU ops (flag sampling).
  function automatic logic needs_t2(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_LDB) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_CMP);
  endfunction

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'h7) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/sap_ctrl_decode.sv
// Combinational (state, opcode, operand) -> datapath control word; zero latency.
// No handshake of its own; driven purely by the sequencer's registered state.
module sap_ctrl_decode
  import sap_ctrl_pkg::*;
(
  input  state_e       state_i,
  input  logic [3:0]   opcode_i,
  input  logic [7:0]   operand_i,
  output ctrl_word_t   ctrl_o
);

  always_comb begin
    ctrl_o = CTRL_DEFAULT;
    case (state_i)
      ST_T1: begin
        case (opcode_i)
          // Immediate goes out a cycle early: the datapath registers its data input.
          OP_LDA, OP_LDB: ctrl_o.data_out = operand_i;
          OP_ADD: begin
            ctrl_o.eu   = 1'b1;
            ctrl_o.la_n = 1'b0;
          end
          OP_SUB: begin
            ctrl_o.eu   = 1'b1;
            ctrl_o.sub  = 1'b1;
            ctrl_o.la_n = 1'b0;
          end
          OP_CMP: begin
            ctrl_o.eu  = 1'b1;
            ctrl_o.sub = 1'b1;
          end
          OP_OUT: begin
            ctrl_o.ea         = 1'b1;
            ctrl_o.out_sel    = 1'b1;
            ctrl_o.out_strobe = 1'b1;
          end
          default: ctrl_o = CTRL_DEFAULT;
        endcase
      end
      ST_T2: begin
        case (opcode_i)
          OP_LDA: begin
            ctrl_o.data_out = operand_i;
            ctrl_o.la_n     = 1'b0;
          end
          OP_LDB: begin
            ctrl_o.data_out = operand_i;
            ctrl_o.lb_n     = 1'b0;
          end
          default: ctrl_o = CTRL_DEFAULT;
        endcase
      end
      default: ctrl_o = CTRL_DEFAULT;
    endcase
  end

endmodule

// File: rtl/sap_ctrl_sequencer.sv
// Expands 12-bit instructions into per-T-state control words; 1-2 cycles per instruction.
// instr_ready only in IDLE; HLT parks in HALT (ready low) until synchronous reset.
module sap_ctrl_sequencer
  import sap_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        cf_in,
  input  logic        zf_in,
  output logic [7:0]  data_out,
  output logic        la_n,
  output logic        lb_n,
  output logic        ea,
  output logic        eu,
  output logic        sub,
  output logic        out_sel,
  output logic        out_strobe,
  output logic        cf_q,
  output logic        zf_q,
  output logic        busy,
  output logic        halted,
  output logic        err,
  output logic [7:0]  retired
);

  state_e      state_q, state_d;
  logic [11:0] ir_q, ir_d;
  logic        cf_flag_q, zf_flag_q;
  logic        err_q;
  logic [7:0]  retired_q;
  logic        retire;
  logic        err_set;
  logic        flag_cap;
  logic [3:0]  opcode;
  ctrl_word_t  ctrl;

  assign opcode = ir_q[11:8];

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    retire   = 1'b0;
    err_set  = 1'b0;
    flag_cap = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          state_d = ST_T1;
          ir_d    = instr;
        end
      end
      ST_T1: begin
        err_set = is_illegal(opcode);
        if (opcode == OP_HLT) begin
          state_d = ST_HALT;
          retire  = 1'b1;
        end else if (needs_t2(opcode)) begin
          state_d = ST_T2;
        end else begin
          state_d = ST_IDLE;
          retire  = 1'b1;
        end
      end
      ST_T2: begin
        // Flags were registered by the datapath on the edge ending the eu cycle.
        flag_cap = is_alu_op(opcode);
        state_d  = ST_IDLE;
        retire   = 1'b1;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ir_q      <= 12'h000;
      cf_flag_q <= 1'b0;
      zf_flag_q <= 1'b0;
      err_q     <= 1'b0;
      retired_q <= 8'h00;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      if (flag_cap) begin
        cf_flag_q <= cf_in;
        zf_flag_q <= zf_in;
      end
      if (err_set) err_q <= 1'b1;
      if (retire) retired_q <= retired_q + 8'd1;
    end
  end

  sap_ctrl_decode u_decode (
    .state_i   (state_q),
    .opcode_i  (opcode),
    .operand_i (ir_q[7:0]),
    .ctrl_o    (ctrl)
  );

  assign la_n        = ctrl.la_n;
  assign lb_n        = ctrl.lb_n;
  assign ea          = ctrl.ea;
  assign eu          = ctrl.eu;
  assign sub         = ctrl.sub;
  assign out_sel     = ctrl.out_sel;
  assign out_strobe  = ctrl.out_strobe;
  assign data_out    = ctrl.data_out;

  assign instr_ready = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_T1) || (state_q == ST_T2);
  assign halted      = (state_q == ST_HALT);
  assign cf_q        = cf_flag_q;
  assign zf_q        = zf_flag_q;
  assign err         = err_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_sap_ctrl_sequencer.sv
// Bench for sap_ctrl_sequencer with a small behavioural model of the 8-bit A/B datapath.
module tb_sap_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] instr = 12'h000;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        cf_in, zf_in;
  logic [7:0]  data_out;
  logic        la_n, lb_n, ea, eu, sub, out_sel, out_strobe;
  logic        cf_q, zf_q, busy, halted, err;
  logic [7:0]  retired;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sap_ctrl_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .cf_in       (cf_in),
    .zf_in       (zf_in),
    .data_out    (data_out),
    .la_n        (la_n),
    .lb_n        (lb_n),
    .ea          (ea),
    .eu          (eu),
    .sub         (sub),
    .out_sel     (out_sel),
    .out_strobe  (out_strobe),
    .cf_q        (cf_q),
    .zf_q        (zf_q),
    .busy        (busy),
    .halted      (halted),
    .err         (err),
    .retired     (retired)
  );

  // Datapath model: registered data input, A/B registers, adder with A + ~B + 1 subtract.
  logic [7:0] dp_a = 8'h00, dp_b = 8'h00, dp_din = 8'h00, dp_out = 8'h00;
  logic       dp_cf = 1'b0, dp_zf = 1'b0;
  logic [8:0] alu;
  logic [7:0] bus;

  always_comb begin
    alu = sub ? ({1'b0, dp_a} + {1'b0, ~dp_b} + 9'd1) : ({1'b0, dp_a} + {1'b0, dp_b});
    bus = ea ? dp_a : (eu ? alu[7:0] : dp_din);
  end

  always @(posedge clk) begin
    dp_din <= data_out;
    if (!la_n) dp_a <= bus;
    if (!lb_n) dp_b <= bus;
    if (eu) begin
      dp_cf <= alu[8];
      dp_zf <= (alu[7:0] == 8'h00);
    end
    if (out_strobe) dp_out <= out_sel ? bus : dp_a;
  end

  assign cf_in = dp_cf;
  assign zf_in = dp_zf;

  int inv_bad = 0;
  int strobes = 0;
  int la_seen = 0;
  always @(negedge clk) begin
    if ((ea && eu) || (!la_n && !lb_n)) inv_bad <= inv_bad + 1;
    if (out_strobe) strobes <= strobes + 1;
    if (!la_n) la_seen <= la_seen + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshake one instruction and count edges until IDLE (or HALT) is reached.
  task automatic issue(input logic [11:0] ins, output int lat);
    int n;
    n = 0;
    instr = ins;
    instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin
      step();
      n++;
    end
    chk("ready_before_issue", int'(instr_ready), 1);
    step();
    instr_valid = 1'b0;
    lat = 0;
    while (!instr_ready && !halted && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"},   int'(instr_ready), 1);
    chk({tag, "_busy"},    int'(busy), 0);
    chk({tag, "_halted"},  int'(halted), 0);
    chk({tag, "_err"},     int'(err), 0);
    chk({tag, "_retired"}, int'(retired), 0);
    chk({tag, "_flags"},   int'({cf_q, zf_q}), 0);
    chk({tag, "_ctrl"},    int'({la_n, lb_n, ea, eu, sub, out_sel, out_strobe, data_out}), 'h6000);
  endtask

  typedef struct {
    logic [11:0] ins;
    int          lat;
    logic [7:0]  a;
    logic        cf;
    logic        zf;
    logic [7:0]  ret;
    logic        err;
    logic [7:0]  outv;
    int          strobes;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int lat;
    int cnt;
    int la0;
    vecs[0]  = '{12'h105, 2, 8'h05, 1'b0, 1'b0, 8'd1,  1'b0, 8'h00, 0};
    vecs[1]  = '{12'h203, 2, 8'h05, 1'b0, 1'b0, 8'd2,  1'b0, 8'h00, 0};
    vecs[2]  = '{12'h300, 2, 8'h08, 1'b0, 1'b0, 8'd3,  1'b0, 8'h00, 0};
    vecs[3]  = '{12'h500, 1, 8'h08, 1'b0, 1'b0, 8'd4,  1'b0, 8'h08, 1};
    vecs[4]  = '{12'h103, 2, 8'h03, 1'b0, 1'b0, 8'd5,  1'b0, 8'h08, 1};
    vecs[5]  = '{12'h203, 2, 8'h03, 1'b0, 1'b0, 8'd6,  1'b0, 8'h08, 1};
    vecs[6]  = '{12'h400, 2, 8'h00, 1'b1, 1'b1, 8'd7,  1'b0, 8'h08, 1};
    vecs[7]  = '{12'h102, 2, 8'h02, 1'b1, 1'b1, 8'd8,  1'b0, 8'h08, 1};
    vecs[8]  = '{12'h600, 2, 8'h02, 1'b0, 1'b0, 8'd9,  1'b0, 8'h08, 1};
    vecs[9]  = '{12'h1FF, 2, 8'hFF, 1'b0, 1'b0, 8'd10, 1'b0, 8'h08, 1};
    vecs[10] = '{12'h201, 2, 8'hFF, 1'b0, 1'b0, 8'd11, 1'b0, 8'h08, 1};
    vecs[11] = '{12'h300, 2, 8'h00, 1'b1, 1'b1, 8'd12, 1'b0, 8'h08, 1};
    vecs[12] = '{12'h900, 1, 8'h00, 1'b1, 1'b1, 8'd13, 1'b1, 8'h08, 1};
    vecs[13] = '{12'h000, 1, 8'h00, 1'b1, 1'b1, 8'd14, 1'b1, 8'h08, 1};

    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check_reset_state("reset");

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].ins, lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_acc", i), int'(dp_a), int'(vecs[i].a));
      chk($sformatf("v%0d_cf", i), int'(cf_q), int'(vecs[i].cf));
      chk($sformatf("v%0d_zf", i), int'(zf_q), int'(vecs[i].zf));
      chk($sformatf("v%0d_retired", i), int'(retired), int'(vecs[i].ret));
      chk($sformatf("v%0d_err", i), int'(err), int'(vecs[i].err));
      chk($sformatf("v%0d_dp_out", i), int'(dp_out), int'(vecs[i].outv));
      chk($sformatf("v%0d_strobes", i), strobes, vecs[i].strobes);
    end

    // HLT, then a held instr_valid must be ignored.
    issue(12'hF00, lat);
    chk("hlt_latency", lat, 1);
    chk("hlt_halted", int'(halted), 1);
    chk("hlt_retired", int'(retired), 15);
    instr = 12'h1AB;
    instr_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (instr_ready || busy || !halted) cnt++;
    end
    chk("halt_hold_violations", cnt, 0);
    chk("halt_acc_untouched", int'(dp_a), 'h00);
    chk("halt_err_sticky", int'(err), 1);
    rst_n = 1'b0;
    step();
    instr_valid = 1'b0;
    rst_n = 1'b1;
    check_reset_state("unhalt");

    // Reset while an LDA sits in T1: no load may follow.
    la0 = la_seen;
    instr = 12'h1AA;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("lda_t1_busy", int'(busy), 1);
    chk("lda_t1_data", int'(data_out), 'hAA);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_ready", int'(instr_ready), 1);
    chk("midrst_busy", int'(busy), 0);
    step();
    step();
    step();
    chk("midrst_no_load", la_seen - la0, 0);
    chk("midrst_acc", int'(dp_a), 'h00);
    chk("midrst_retired", int'(retired), 0);

    // 256 NOPs wrap the retired counter.
    for (int i = 0; i < 256; i++) begin
      issue(12'h000, lat);
      if (i == 254) chk("nop_retired_255", int'(retired), 255);
    end
    chk("nop_retired_wrap", int'(retired), 0);
    chk("nop_err_clear", int'(err), 0);

    chk("invariant_violations", inv_bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d so far", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule
